// File: rtl/usb_tx_pkg.sv
// Shared encodings for the USB transmit path: packet commands, handshake PIDs
// and the scheduler FSM states.
package usb_tx_pkg;

   localparam int unsigned CNT_W = 16;
   localparam int unsigned PKT_W = 4;
   localparam int unsigned PID_W = 2;

   typedef enum logic [PKT_W-1:0] {
      PKT_IDLE  = 4'd0,
      PKT_DATA0 = 4'd1,
      PKT_DATA1 = 4'd2,
      PKT_ACK   = 4'd3,
      PKT_NAK   = 4'd4,
      PKT_STALL = 4'd5
   } tx_pkt_e;

   typedef enum logic [PID_W-1:0] {
      HS_ACK   = 2'd0,
      HS_NAK   = 2'd1,
      HS_STALL = 2'd2,
      HS_BAD   = 2'd3
   } hs_pid_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT_START,
      ST_ACTIVE,
      ST_GAP
   } state_e;

   function automatic tx_pkt_e hs_to_pkt(input hs_pid_e pid);
      case (pid)
         HS_ACK:   return PKT_ACK;
         HS_NAK:   return PKT_NAK;
         HS_STALL: return PKT_STALL;
         default:  return PKT_IDLE;
      endcase
   endfunction

endpackage

// File: rtl/usb_tx_scheduler_if.sv
// Request, transmitter and status signals of the TX scheduler.
// master = requesters/transmitter side, slave = the scheduler.
interface usb_tx_scheduler_if;

   logic                          hs_req;
   logic [usb_tx_pkg::PID_W-1:0]  hs_pid;
   logic                          hs_grant;
   logic                          data_req;
   logic                          data_grant;
   logic                          toggle_clear;
   logic                          ack_rcvd;
   logic [usb_tx_pkg::PKT_W-1:0]  TX_Packet;
   logic                          TX_Transfer_Active;
   logic                          TX_Error;
   logic                          busy;
   logic                          done;
   logic                          err;
   logic                          toggle;

   modport master (
      output hs_req, hs_pid, data_req, toggle_clear, ack_rcvd,
             TX_Transfer_Active, TX_Error,
      input  hs_grant, data_grant, TX_Packet, busy, done, err, toggle
   );

   modport slave (
      input  hs_req, hs_pid, data_req, toggle_clear, ack_rcvd,
             TX_Transfer_Active, TX_Error,
      output hs_grant, data_grant, TX_Packet, busy, done, err, toggle
   );

endinterface

// File: rtl/usb_tx_toggle.sv
// Endpoint DATA0/DATA1 toggle and the pending flag of the last data packet.
module usb_tx_toggle (
   input  logic clk,
   input  logic rst,
   input  logic data_grant,
   input  logic ack_rcvd,
   input  logic toggle_clear,
   output logic toggle
);

   logic pending;

   // A failed data packet keeps pending set so the retried packet can still be ACKed.
   always_ff @(posedge clk) begin
      if (rst) begin
         toggle  <= 1'b0;
         pending <= 1'b0;
      end else begin
         if (toggle_clear)
            toggle <= 1'b0;
         else if (ack_rcvd && pending)
            toggle <= ~toggle;

         if (data_grant)
            pending <= 1'b1;
         else if (toggle_clear || ack_rcvd)
            pending <= 1'b0;
      end
   end

endmodule

// File: rtl/usb_tx_scheduler.sv
// Arbitrates handshake vs. data packet requests, sequences one transmitter
// command at a time and enforces the inter-packet gap.
module usb_tx_scheduler
   import usb_tx_pkg::*;
#(
   parameter int unsigned IPG_CYCLES    = 16,
   parameter int unsigned START_TIMEOUT = 64
) (
   input logic              clk,
   input logic              rst,
   usb_tx_scheduler_if.slave bus
);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [PKT_W-1:0]   pkt_q, pkt_d;
   logic               flag_q, flag_d;
   logic               hs_grant_q, hs_grant_d;
   logic               data_grant_q, data_grant_d;
   logic               done_q, done_d;
   logic               err_q, err_d;
   logic               busy_q;
   logic               toggle_q;
   logic               err_seen;

   assign err_seen = flag_q | bus.TX_Error;

   // Next state and next registered outputs
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q + CNT_W'(1);
      pkt_d        = pkt_q;
      flag_d       = flag_q;
      hs_grant_d   = 1'b0;
      data_grant_d = 1'b0;
      done_d       = 1'b0;
      err_d        = 1'b0;

      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (bus.hs_req) begin
               hs_grant_d = 1'b1;
               if (hs_pid_e'(bus.hs_pid) == HS_BAD) begin
                  err_d   = 1'b1;
                  state_d = ST_GAP;
               end else begin
                  pkt_d   = hs_to_pkt(hs_pid_e'(bus.hs_pid));
                  state_d = ST_WAIT_START;
               end
            end else if (bus.data_req) begin
               data_grant_d = 1'b1;
               pkt_d        = toggle_q ? PKT_DATA1 : PKT_DATA0;
               state_d      = ST_WAIT_START;
            end
         end

         // A start on the final timeout cycle takes priority over the timeout.
         ST_WAIT_START: begin
            if (bus.TX_Transfer_Active) begin
               pkt_d   = PKT_IDLE;
               flag_d  = bus.TX_Error;
               cnt_d   = '0;
               state_d = ST_ACTIVE;
            end else if (cnt_q == CNT_W'(START_TIMEOUT - 1)) begin
               pkt_d   = PKT_IDLE;
               err_d   = 1'b1;
               cnt_d   = '0;
               state_d = ST_GAP;
            end
         end

         ST_ACTIVE: begin
            flag_d = err_seen;
            if (!bus.TX_Transfer_Active) begin
               done_d  = ~err_seen;
               err_d   = err_seen;
               flag_d  = 1'b0;
               cnt_d   = '0;
               state_d = ST_GAP;
            end
         end

         ST_GAP: begin
            if (cnt_q == CNT_W'(IPG_CYCLES - 1)) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end
         end

         default: begin
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         pkt_q        <= '0;
         flag_q       <= 1'b0;
         hs_grant_q   <= 1'b0;
         data_grant_q <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         pkt_q        <= pkt_d;
         flag_q       <= flag_d;
         hs_grant_q   <= hs_grant_d;
         data_grant_q <= data_grant_d;
         done_q       <= done_d;
         err_q        <= err_d;
         busy_q       <= (state_d != ST_IDLE);
      end
   end

   usb_tx_toggle u_toggle (
      .clk          (clk),
      .rst          (rst),
      .data_grant   (data_grant_d),
      .ack_rcvd     (bus.ack_rcvd),
      .toggle_clear (bus.toggle_clear),
      .toggle       (toggle_q)
   );

   assign bus.hs_grant   = hs_grant_q;
   assign bus.data_grant = data_grant_q;
   assign bus.TX_Packet  = pkt_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.err        = err_q;
   assign bus.toggle     = toggle_q;

endmodule

// File: tb/tb_usb_tx_scheduler.sv
// Directed bench for usb_tx_scheduler with hand-computed expectations.
module tb_usb_tx_scheduler;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_err;

   usb_tx_scheduler_if bus();

   usb_tx_scheduler #(
      .IPG_CYCLES    (16),
      .START_TIMEOUT (64)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (bus.busy && n < 100) begin
         tick();
         n++;
      end
      check("idle_reached", 32'(bus.busy), 0);
   endtask

   // Transmitter model: active for len cycles, optional error pulse at cycle err_at.
   task automatic xmit(input int len, input int err_at, input string tag, input bit exp_err);
      bus.TX_Transfer_Active = 1'b1;
      for (int i = 0; i < len; i++) begin
         bus.TX_Error = (i == err_at);
         tick();
         if (i == 0) check({tag, "_pkt_idle"}, 32'(bus.TX_Packet), 0);
      end
      bus.TX_Error           = 1'b0;
      bus.TX_Transfer_Active = 1'b0;
      tick();
      check({tag, "_done"}, 32'(bus.done), 32'(!exp_err));
      check({tag, "_err"},  32'(bus.err),  32'(exp_err));
   endtask

   task automatic data_pkt(input string tag, input int exp_pkt);
      wait_idle();
      bus.data_req = 1'b1;
      tick();
      check({tag, "_grant"}, 32'(bus.data_grant), 1);
      check({tag, "_pkt"},   32'(bus.TX_Packet),  32'(exp_pkt));
      bus.data_req = 1'b0;
      xmit(3, -1, tag, 1'b0);
   endtask

   task automatic hs_start(input logic [1:0] pid);
      wait_idle();
      bus.hs_pid = pid;
      bus.hs_req = 1'b1;
      tick();
      bus.hs_req = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_pkt"},   32'(bus.TX_Packet),  0);
      check({tag, "_busy"},  32'(bus.busy),       0);
      check({tag, "_tog"},   32'(bus.toggle),     0);
      check({tag, "_hsg"},   32'(bus.hs_grant),   0);
      check({tag, "_dg"},    32'(bus.data_grant), 0);
      check({tag, "_done"},  32'(bus.done),       0);
      check({tag, "_err"},   32'(bus.err),        0);
   endtask

   initial begin
      int n;
      int ndone;
      int nerr;
      logic [3:0] pkt_seen;

      n_vec = 0;
      n_err = 0;
      bus.hs_req = 0; bus.hs_pid = 0; bus.data_req = 0;
      bus.toggle_clear = 0; bus.ack_rcvd = 0;
      bus.TX_Transfer_Active = 0; bus.TX_Error = 0;
      rst = 1'b1;
      repeat (3) tick();
      check_all_zero("reset");
      rst = 1'b0;
      tick();

      // Handshake ACK, then IPG spacing to a NAK
      bus.hs_pid = 2'd0;
      bus.hs_req = 1'b1;
      tick();
      check("hs_grant", 32'(bus.hs_grant),   1);
      check("hs_pkt",   32'(bus.TX_Packet),  3);
      check("hs_busy",  32'(bus.busy),       1);
      bus.hs_req = 1'b0;
      tick();
      tick();
      check("hs_hold",  32'(bus.TX_Packet),  3);
      xmit(20, -1, "hs", 1'b0);
      bus.hs_pid = 2'd1;
      bus.hs_req = 1'b1;
      n = 0; ndone = 0;
      do begin
         tick();
         n++;
         if (bus.done) ndone++;
      end while (!bus.hs_grant && n < 60);
      check("ipg_cycles", 32'(n), 17);
      check("done_once",  32'(ndone), 0);
      check("nak_pkt",    32'(bus.TX_Packet), 4);
      bus.hs_req = 1'b0;
      xmit(5, -1, "nak", 1'b0);

      // Arbitration: handshake before data
      wait_idle();
      bus.hs_pid = 2'd0;
      bus.hs_req = 1'b1;
      bus.data_req = 1'b1;
      tick();
      check("arb_hs_grant",   32'(bus.hs_grant),   1);
      check("arb_data_grant", 32'(bus.data_grant), 0);
      check("arb_pkt",        32'(bus.TX_Packet),  3);
      bus.hs_req = 1'b0;
      xmit(4, -1, "arb_hs", 1'b0);
      n = 0;
      do begin
         tick();
         n++;
      end while (!bus.data_grant && n < 60);
      check("arb_data_ipg", 32'(n), 17);
      check("arb_data_pkt", 32'(bus.TX_Packet), 1);
      bus.data_req = 1'b0;
      xmit(4, -1, "arb_data", 1'b0);

      // Toggle behaviour
      bus.ack_rcvd = 1'b1;
      tick();
      bus.ack_rcvd = 1'b0;
      check("tog_after_ack", 32'(bus.toggle), 1);
      data_pkt("tog_d1", 2);
      bus.toggle_clear = 1'b1;
      bus.ack_rcvd = 1'b1;
      tick();
      bus.toggle_clear = 1'b0;
      bus.ack_rcvd = 1'b0;
      check("tog_clear_wins", 32'(bus.toggle), 0);
      bus.ack_rcvd = 1'b1;
      tick();
      bus.ack_rcvd = 1'b0;
      check("ack_not_pending", 32'(bus.toggle), 0);
      data_pkt("tog_a", 1);
      data_pkt("tog_b", 1);

      // Start timeout
      wait_idle();
      bus.data_req = 1'b1;
      tick();
      check("to_grant", 32'(bus.data_grant), 1);
      check("to_pkt",   32'(bus.TX_Packet),  1);
      bus.data_req = 1'b0;
      n = 0;
      do begin
         tick();
         n++;
      end while (!bus.err && n < 100);
      check("to_cycles",   32'(n), 64);
      check("to_pkt_idle", 32'(bus.TX_Packet), 0);
      check("to_done",     32'(bus.done), 0);
      check("to_toggle",   32'(bus.toggle), 0);
      tick();
      check("to_err_once", 32'(bus.err), 0);

      // Start on the last timeout cycle wins
      wait_idle();
      bus.data_req = 1'b1;
      tick();
      check("edge_grant", 32'(bus.data_grant), 1);
      bus.data_req = 1'b0;
      repeat (63) tick();
      bus.TX_Transfer_Active = 1'b1;
      tick();
      check("edge_err",  32'(bus.err),       0);
      check("edge_busy", 32'(bus.busy),      1);
      check("edge_pkt",  32'(bus.TX_Packet), 0);
      repeat (3) tick();
      bus.TX_Transfer_Active = 1'b0;
      tick();
      check("edge_done", 32'(bus.done), 1);

      // Transmitter errors: mid-packet and coincident with start
      hs_start(2'd0);
      xmit(10, 4, "txerr", 1'b1);
      hs_start(2'd0);
      xmit(10, 0, "txerr_start", 1'b1);

      // Illegal handshake PID
      wait_idle();
      bus.hs_pid = 2'd3;
      bus.hs_req = 1'b1;
      tick();
      check("bad_grant", 32'(bus.hs_grant), 1);
      bus.hs_req = 1'b0;
      nerr = bus.err ? 1 : 0;
      pkt_seen = bus.TX_Packet;
      repeat (20) begin
         tick();
         if (bus.err) nerr++;
         pkt_seen = pkt_seen | bus.TX_Packet;
      end
      check("bad_err_count", 32'(nerr), 1);
      check("bad_pkt",       32'(pkt_seen), 0);

      // Pending survives errored data packets
      bus.ack_rcvd = 1'b1;
      tick();
      bus.ack_rcvd = 1'b0;
      check("pre_rst_toggle", 32'(bus.toggle), 1);

      // Reset mid-ACTIVE with a data request waiting
      wait_idle();
      bus.hs_pid = 2'd2;
      bus.hs_req = 1'b1;
      tick();
      check("rst_pkt", 32'(bus.TX_Packet), 5);
      bus.hs_req = 1'b0;
      bus.TX_Transfer_Active = 1'b1;
      repeat (3) tick();
      bus.data_req = 1'b1;
      tick();
      check("rst_no_grant", 32'(bus.data_grant), 0);
      rst = 1'b1;
      tick();
      check_all_zero("mid_rst");
      rst = 1'b0;
      bus.TX_Transfer_Active = 1'b0;
      tick();
      check("regrant",     32'(bus.data_grant), 1);
      check("regrant_pkt", 32'(bus.TX_Packet),  1);
      bus.data_req = 1'b0;
      xmit(3, -1, "post_rst", 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule

// File: doc/usb_tx_scheduler.md
# usb_tx_scheduler

Sequencer and arbiter in front of the USB transmit datapath. It takes packet requests from two sources, the RX-side handshake responder (ACK/NAK/STALL) and the endpoint data path (DATA0/DATA1). It issues one packet command at a time on `TX_Packet`, tracks the transmitter through `TX_Transfer_Active`/`TX_Error`, enforces a minimum inter-packet gap, and owns the endpoint data-toggle bit.

## Interface
Parameters:
- `IPG_CYCLES`, 16: minimum idle cycles between end of one packet and the next issue (≥1).
- `START_TIMEOUT`, 64: cycles allowed from issue until `TX_Transfer_Active` rises (≥2).

Ports:
- `clk`  in  1  system clock; all logic on rising edge; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `hs_req`  in  1  handshake request; level, held until `hs_grant`.
- `hs_pid`  in  2  0=ACK, 1=NAK, 2=STALL; 3 is illegal and is granted but rejected with `err`.
- `hs_grant`  out  1  one-cycle pulse: handshake request accepted.
- `data_req`  in  1  data packet request; level, held until `data_grant`.
- `data_grant`  out  1  one-cycle pulse: data request accepted.
- `toggle_clear`  in  1  pulse: force toggle to DATA0 (SETUP received).
- `ack_rcvd`  in  1  pulse: host ACKed the last data packet.
- `TX_Packet`  out  4  command to transmitter (encodings in Structure).
- `TX_Transfer_Active`  in  1  transmitter busy.
- `TX_Error`  in  1  transmitter error, sampled while busy.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse: packet completed without error.
- `err`  out  1  one-cycle pulse: start timeout, `TX_Error`, or illegal `hs_pid`.
- `toggle`  out  1  current data toggle (0=DATA0, 1=DATA1).

## Operation
States: IDLE, WAIT_START, ACTIVE, GAP.
- IDLE: if `hs_req`, pulse `hs_grant`, latch PID, drive the command and go to WAIT_START. Otherwise, if `data_req`, pulse `data_grant`, drive DATA0/DATA1 per `toggle`, set `data_pending`, and go to WAIT_START. Handshake always wins when both requests are high. If `hs_pid`=3: grant, pulse `err` on the next cycle, drive no command, and go to GAP.
- WAIT_START: hold `TX_Packet` and count. When `TX_Transfer_Active`=1, drive `TX_Packet`=IDLE and go to ACTIVE. If the count reaches `START_TIMEOUT`, drive `TX_Packet`=IDLE, pulse `err`, and go to GAP.
- ACTIVE: OR `TX_Error` into a sticky flag. When `TX_Transfer_Active` falls to 0, pulse `done` if the flag is clear and `err` if it is set, clear the flag, and go to GAP.
- GAP: count `IPG_CYCLES` cycles, then return to IDLE. Requests are not granted during GAP.
- Toggle register: reset 0. `ack_rcvd` while `data_pending`=1 flips `toggle` and clears `data_pending`. `ack_rcvd` with `data_pending`=0 is ignored. `toggle_clear` sets `toggle`=0 and clears `data_pending`, and wins over a simultaneous `ack_rcvd`. A new data grant sets `data_pending` again. A data packet that ends in `err` still leaves `data_pending` set, because the host retries.
- Counters: 16-bit, zeroed on every state entry; parameters must fit in 16 bits.

## Timing
- Reset: state IDLE; `TX_Packet`=0, `hs_grant`=`data_grant`=`done`=`err`=0, `busy`=0, `toggle`=0, `data_pending`=0, counters 0. Reset mid-packet aborts immediately with no `err`/`done` pulse.
- Grant pulse and first `TX_Packet` drive occur on the same rising edge that leaves IDLE, so `busy` rises on that edge too. Latency from request to command is 1 cycle.
- `done`/`err` are asserted the cycle after `TX_Transfer_Active` is sampled low. GAP starts on that same edge.
- Earliest next issue comes `IPG_CYCLES`+1 cycles after `done`.
- A timeout fires on the cycle where the count equals `START_TIMEOUT`−1 with `TX_Transfer_Active` still 0. If `TX_Transfer_Active` rises on that exact cycle, the start wins and there is no `err`.
- `TX_Error` arriving in WAIT_START on the same cycle `TX_Transfer_Active` rises is captured.
- `toggle` updates the cycle after `ack_rcvd`/`toggle_clear`. A data grant on that same cycle uses the old value.

## Structure
- Package `usb_tx_pkg`:
  - `TX_Packet` encodings: IDLE=0, DATA0=1, DATA1=2, ACK=3, NAK=4, STALL=5.
  - `hs_pid` codes.
  - FSM state enum.
  - These encodings are shared with the transmitter and packet compiler.
- One natural sub-module, `usb_tx_toggle`: owns the toggle register and `data_pending`, with inputs `data_grant`, `ack_rcvd`, `toggle_clear`. The FSM and arbitration stay in the top module.

## Test plan
- Handshake path: `hs_req`=1 and `hs_pid`=0. Required: `hs_grant` and `TX_Packet`=3 on the next edge. Model raises `TX_Transfer_Active` 3 cycles later and holds it 20 cycles, then `done` pulses once and the next grant is no earlier than 17 cycles after `done`.
- Arbitration: `hs_req` and `data_req` rise together. Required: handshake granted first (`TX_Packet`=3). The data grant follows after the gap with `TX_Packet`=1.
- Toggle: data packet, `ack_rcvd`, then data packet. Required: `TX_Packet` values 1 then 2. With no `ack_rcvd` between packets, both are 1. `toggle_clear` coincident with `ack_rcvd` leaves `toggle`=0.
- Timeout: data grant, `TX_Transfer_Active` held at 0. Required: `err` pulses once after 64 cycles, `TX_Packet` returns to 0, and `toggle` is unchanged.
- Error: `TX_Error` pulses mid-ACTIVE. Required: `err` (not `done`) on the falling edge of active. `hs_pid`=3 → grant plus `err` with `TX_Packet` never nonzero.
- Reset mid-ACTIVE: all outputs are 0 the next cycle, and a pending request is re-granted normally after reset.
